// File: rtl/lut_cfg_ctrl.sv
// Runtime-loadable bank of 4-input LUTs. Tables are written as whole 16-bit words
// over a byte-wide valid/ready stream and every slot is evaluated each cycle.
module lut_cfg_ctrl #(
  parameter int          NUM_LUTS     = 4,
  parameter logic [15:0] INIT_DEFAULT = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  input  logic [7:0]            cfg_data,
  output logic                  cfg_ready,
  output logic                  cfg_done,
  output logic                  cfg_err,
  input  logic                  err_clr,
  input  logic [4*NUM_LUTS-1:0] lut_in,
  output logic [NUM_LUTS-1:0]   lut_out,
  output logic [1:0]            state_dbg
);

  // Handshake: a byte moves on a rising edge where cfg_valid && cfg_ready; cfg_ready
  // is registered from state alone and is low only during the single COMMIT cycle.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LO     = 2'd1,
    S_HI     = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_t      state;
  logic [1:0]  slot;
  logic        slot_ok;
  logic        is_clear;
  logic [15:0] shadow;
  logic [15:0] active [NUM_LUTS];

  logic       xfer;
  logic [1:0] opcode;
  logic       hdr_slot_ok;
  logic       err_set;

  assign xfer        = cfg_valid & cfg_ready;
  assign opcode      = cfg_data[7:6];
  assign hdr_slot_ok = (int'({30'd0, cfg_data[1:0]}) < NUM_LUTS);
  assign err_set     = xfer && (state == S_IDLE) &&
                       ((opcode == OP_RSVD) || ((opcode == OP_WRITE) && !hdr_slot_ok));
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cfg_ready <= 1'b1;
      cfg_done  <= 1'b0;
      slot      <= 2'd0;
      slot_ok   <= 1'b0;
      is_clear  <= 1'b0;
      shadow    <= 16'h0000;
      for (int k = 0; k < NUM_LUTS; k++) active[k] <= INIT_DEFAULT;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            case (opcode)
              OP_WRITE: begin
                slot     <= cfg_data[1:0];
                slot_ok  <= hdr_slot_ok;
                is_clear <= 1'b0;
                state    <= S_LO;
              end
              OP_CLEAR: begin
                is_clear  <= 1'b1;
                state     <= S_COMMIT;
                cfg_ready <= 1'b0;
                cfg_done  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_LO: begin
          if (xfer) begin
            shadow[7:0] <= cfg_data;
            state       <= S_HI;
          end
        end
        S_HI: begin
          if (xfer) begin
            shadow[15:8] <= cfg_data;
            state        <= S_COMMIT;
            cfg_ready    <= 1'b0;
            cfg_done     <= 1'b1;
          end
        end
        S_COMMIT: begin
          // Whole-word update only; an out-of-range WRITE commits nothing.
          state     <= S_IDLE;
          cfg_ready <= 1'b1;
          for (int k = 0; k < NUM_LUTS; k++) begin
            if (is_clear) active[k] <= INIT_DEFAULT;
            else if (slot_ok && (slot == 2'(k))) active[k] <= shadow;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else if (err_set) cfg_err <= 1'b1;
    else if (err_clr) cfg_err <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_out <= '0;
    end else begin
      for (int k = 0; k < NUM_LUTS; k++) lut_out[k] <= active[k][lut_in[4*k +: 4]];
    end
  end

endmodule

// File: tb/tb_lut_cfg_ctrl.sv
// Bench for lut_cfg_ctrl: command-level driver, table model and per-cycle output scoreboard.
module tb_lut_cfg_ctrl;

  localparam int          NL   = 3;
  localparam int          LW   = 4 * NL;
  localparam logic [15:0] INIT = 16'h1234;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [7:0]    cfg_data = 8'h00;
  logic          err_clr = 1'b0;
  logic [LW-1:0] lut_in = '0;
  logic          cfg_ready, cfg_done, cfg_err;
  logic [NL-1:0] lut_out;
  logic [1:0]    state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0]   model_tbl [NL];
  logic [15:0]   init_v = INIT;
  logic          exp_err = 1'b0;
  logic          exp_done = 1'b0;
  logic [NL-1:0] exp_lut = '0;
  bit            rand_lut = 1'b1;
  bit            mon_en = 1'b0;
  int            pend_kind = 0;
  logic [1:0]    pend_slot = 2'd0;
  logic [15:0]   pend_tbl = 16'h0;

  always #5 clk = ~clk;

  lut_cfg_ctrl #(.NUM_LUTS(NL), .INIT_DEFAULT(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_clr(err_clr),
    .lut_in(lut_in), .lut_out(lut_out), .state_dbg(state_dbg)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected LUT result is captured at each rising edge from the model tables of that moment.
  always @(posedge clk) begin
    if (!rst_n) exp_lut = '0;
    else for (int k = 0; k < NL; k++) exp_lut[k] = model_tbl[k][lut_in[4*k +: 4]];
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check_val("lut_out", 32'(lut_out), rst_n ? 32'(exp_lut) : 32'd0);
      check_val("cfg_done", 32'(cfg_done), 32'(exp_done));
      check_val("cfg_ready", 32'(cfg_ready), 32'(!exp_done));
      check_val("cfg_err", 32'(cfg_err), 32'(exp_err));
    end
  end

  task automatic reset_model();
    for (int k = 0; k < NL; k++) model_tbl[k] = INIT;
    exp_err = 1'b0;
    exp_done = 1'b0;
    pend_kind = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_lut) lut_in = LW'($urandom);
  endtask

  task automatic put_byte(input logic [7:0] b, input bit clr, input bit set_err, input bit last);
    cfg_valid = 1'b1;
    cfg_data  = b;
    err_clr   = clr;
    check_val("ready_before_byte", 32'(cfg_ready), 32'd1);
    tick();
    if (set_err) exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
    exp_done  = last;
    cfg_valid = 1'b0;
    err_clr   = 1'b0;
    cfg_data  = 8'($urandom);
  endtask

  // A reserved header offered during COMMIT must not be taken.
  task automatic commit_cycle();
    cfg_valid = 1'($urandom);
    cfg_data  = 8'hC3;
    tick();
    exp_done  = 1'b0;
    cfg_valid = 1'b0;
    if (pend_kind == 1 && int'({30'd0, pend_slot}) < NL) model_tbl[pend_slot] = pend_tbl;
    if (pend_kind == 2) for (int k = 0; k < NL; k++) model_tbl[k] = INIT;
    pend_kind = 0;
  endtask

  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b0;
      cfg_data  = 8'($urandom);
      err_clr   = clr;
      tick();
      if (clr) exp_err = 1'b0;
      err_clr = 1'b0;
    end
  endtask

  task automatic do_write(input logic [1:0] slot, input logic [15:0] tbl,
                          input int st_lo, input int st_hi, input bit clr);
    put_byte({2'b01, 4'($urandom), slot}, clr, (int'({30'd0, slot}) >= NL), 1'b0);
    pend_kind = 1;
    pend_slot = slot;
    pend_tbl  = tbl;
    idle(st_lo, 1'b0);
    put_byte(tbl[7:0], 1'b0, 1'b0, 1'b0);
    idle(st_hi, 1'b0);
    put_byte(tbl[15:8], 1'b0, 1'b0, 1'b1);
    commit_cycle();
  endtask

  task automatic do_clear(input bit clr);
    put_byte({2'b10, 4'($urandom), 2'($urandom)}, clr, 1'b0, 1'b1);
    pend_kind = 2;
    commit_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [3:0] sel;
    reset_model();
    mon_en = 1'b1;

    // Reset values with random selects.
    rst_n = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
    idle(3, 1'b0);

    // WRITE slot 1 with 16'h2828, then sweep slot-1 selects.
    put_byte(8'h41, 1'b0, 1'b0, 1'b0);
    pend_kind = 1; pend_slot = 2'd1; pend_tbl = 16'h2828;
    put_byte(8'h28, 1'b0, 1'b0, 1'b0);
    put_byte(8'h28, 1'b0, 1'b0, 1'b1);
    commit_cycle();
    rand_lut = 1'b0;
    for (int s = 0; s < 16; s++) begin
      lut_in = LW'($urandom);
      lut_in[7:4] = 4'(s);
      tick();
      check_val("sweep_slot1", 32'(lut_out[1]), 32'(s == 3 || s == 5 || s == 11 || s == 13));
    end
    rand_lut = 1'b1;

    // Stall five cycles between low and high bytes.
    do_write(2'd0, 16'hFFFF, 0, 5, 1'b0);
    idle(1, 1'b0);
    check_val("slot0_all_ones", 32'(lut_out[0]), 32'd1);

    // Load everything with ones, then CLEAR_ALL and sweep all slots.
    for (int k = 0; k < NL; k++) do_write(2'(k), 16'hFFFF, 0, 0, 1'b0);
    do_clear(1'b0);
    rand_lut = 1'b0;
    for (int s = 0; s < 16; s++) begin
      lut_in = {NL{4'(s)}};
      tick();
      check_val("clear_sweep", 32'(lut_out), 32'({NL{init_v[s]}}));
    end
    rand_lut = 1'b1;

    // Reserved opcode, out-of-range WRITE, clear, and set-beats-clear.
    put_byte(8'hC0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    do_write(2'd3, 16'hFFFF, 0, 0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    put_byte(8'hC0, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b0);

    // Reset while in HI of a WRITE to slot 2; next byte must decode as a header.
    put_byte(8'h42, 1'b0, 1'b0, 1'b0);
    put_byte(8'hFF, 1'b0, 1'b0, 1'b0);
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    rst_n = 1'b0;
    reset_model();
    cfg_valid = 1'b0;
    idle(2, 1'b0);
    rst_n = 1'b1;
    idle(1, 1'b0);
    put_byte(8'hC0, 1'b0, 1'b1, 1'b0);
    rand_lut = 1'b0;
    lut_in = LW'($urandom);
    lut_in[11:8] = 4'hC;
    tick();
    check_val("slot2_after_reset", 32'(lut_out[2]), 32'(init_v[12]));
    rand_lut = 1'b1;
    idle(1, 1'b1);

    // Randomized command mix.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: put_byte({2'b00, 6'($urandom)}, ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
        1: put_byte({2'b11, 6'($urandom)}, ($urandom_range(0, 3) == 0), 1'b1, 1'b0);
        2: do_clear($urandom_range(0, 3) == 0);
        9: idle($urandom_range(1, 3), 1'($urandom));
        default: do_write(2'($urandom_range(0, 3)), 16'($urandom),
                          $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
      endcase
    end

    // Final explicit sweep of every slot against the model.
    rand_lut = 1'b0;
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s);
      lut_in = {NL{sel}};
      tick();
      for (int k = 0; k < NL; k++) check_val("final_sweep", 32'(lut_out[k]), 32'(model_tbl[k][sel]));
    end
    idle(2, 1'b0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lut_cfg_ctrl.md
# lut_cfg_ctrl

Runtime configuration controller for a bank of `NUM_LUTS` 4-input lookup tables. It replaces the fixed 16-bit truth-table parameter of the static LUT cell with registers loaded over a byte-wide valid/ready stream. It evaluates every LUT each cycle from the currently active tables. It sits between the chip's configuration port and the programmable-logic fabric.

## Interface
- `NUM_LUTS`, 4: number of LUT slots, range 1..4; the slot index is 2 bits.
- `INIT_DEFAULT`, 16'h0000: table value loaded into every slot at reset and by CLEAR_ALL.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `cfg_valid` input 1: a configuration byte is present on `cfg_data`.
- `cfg_data` input 8: configuration byte.
- `cfg_ready` output 1: the controller accepts `cfg_data` this cycle.
- `cfg_done` output 1: one-cycle pulse when a command commits.
- `cfg_err` output 1: sticky error flag.
- `err_clr` input 1: clears `cfg_err`.
- `lut_in` input 4*NUM_LUTS: select inputs; slot k uses bits [4k+3:4k], with bit 4k as I0.
- `lut_out` output NUM_LUTS: registered LUT results.

## Operation
- **Transfer rule.** A byte transfers on any rising edge where `cfg_valid` and `cfg_ready` are both 1. `cfg_data` is ignored at all other times.
- **Header byte:**
  - bits [7:6] carry the opcode: 00 NOP, 01 WRITE, 10 CLEAR_ALL, 11 reserved.
  - bits [1:0] carry the slot index.
  - bits [5:2] are ignored.
- **Reset state:** FSM in IDLE; all active tables = `INIT_DEFAULT`; `cfg_ready`=1; `cfg_done`=0; `cfg_err`=0; `lut_out`=0.
- **FSM states:**
  - IDLE: `cfg_ready`=1. Header accepted with opcode:
    - NOP: stay in IDLE.
    - WRITE: latch the slot, go to LO.
    - CLEAR_ALL: go to COMMIT.
    - 11: set `cfg_err`, stay in IDLE.
  - LO: `cfg_ready`=1. The accepted byte goes to shadow[7:0]; go to HI.
  - HI: `cfg_ready`=1. The accepted byte goes to shadow[15:8]; go to COMMIT.
  - COMMIT: `cfg_ready`=0 for exactly one cycle, then return to IDLE. `cfg_done`=1 during this cycle. On the edge leaving COMMIT:
    - WRITE: active[slot] <= shadow.
    - CLEAR_ALL: every active table <= `INIT_DEFAULT`.
- **Out-of-range slot.** WRITE with slot ≥ `NUM_LUTS`:
  - `cfg_err` is set when the header is accepted.
  - The two data bytes are still consumed and COMMIT still occurs with `cfg_done`=1.
  - No table changes.
- **No partial updates.** A slot's active table is only ever updated as a whole 16 bits in COMMIT. Partial loads never reach `lut_out`.
- **Idle stalls.** `cfg_valid`=0 in LO or HI holds the state indefinitely. There is no timeout.
- **Error flag.** `cfg_err` is set by an error event and cleared by `err_clr`. If both occur in the same cycle, set wins.
- **LUT evaluation.** Every cycle, `lut_out[k]` <= active[k][`lut_in`[4k+3:4k]], i.e. table bit index = {I3,I2,I1,I0}.

## Timing
- `lut_in` to `lut_out`: 1-cycle latency; the output is registered.
- Table update visibility: on the edge leaving COMMIT, `lut_out` still samples the old table. The first `lut_out` computed with the new table appears one edge later.
- WRITE command: 3 accepted bytes plus 1 COMMIT cycle. With `cfg_valid` held high, one command completes every 4 cycles.
- CLEAR_ALL: 1 byte plus 1 COMMIT cycle, so 2 cycles.
- `cfg_ready` is a function of state only and is registered. It never depends combinationally on `cfg_valid`.
- Asserting `rst_n` low mid-command:
  - The command is aborted immediately and the FSM returns to IDLE.
  - The shadow contents are discarded.
  - All tables return to `INIT_DEFAULT`.
  - All outputs take their reset values.

## Test plan
- **Reset values.** Apply reset with random `lut_in` → `lut_out`=0 every cycle, `cfg_ready`=1, `cfg_err`=0.
- **WRITE and evaluate.** Stream 0x41, 0x28, 0x28 (WRITE slot 1, table 16'h2828), then sweep `lut_in[7:4]` over 0..15:
  - `cfg_ready` goes low for exactly 1 cycle and `cfg_done` pulses once.
  - `lut_out[1]` = 1 only for selects 3, 5, 11, 13, each one cycle after the input is applied.
  - Other slots are unchanged.
- **Stalled stream.** Deassert `cfg_valid` for 5 cycles between the low and high bytes of a WRITE to slot 0 (table 16'hFFFF):
  - No `cfg_done` and no table change during the stall.
  - The commit occurs only after the high byte is accepted; `lut_out[0]`=1 afterwards.
- **CLEAR_ALL.** After loading all slots with 16'hFFFF, send 0x80:
  - `cfg_done` pulses 1 cycle after the header.
  - Two cycles later every `lut_out` bit is 0 for all selects.
- **Errors.** Sending 0xC0 sets `cfg_err` with no other effect. Then:
  - With `NUM_LUTS`=2, WRITE slot 3 with 0x43, 0xFF, 0xFF: `cfg_err` stays set, `cfg_done` pulses, slots 0 and 1 are unchanged.
  - Pulsing `err_clr` clears `cfg_err` on the next edge.
- **Reset mid-command.** Assert `rst_n` low while in state HI of a WRITE to slot 2:
  - After release, `lut_out[2]` reflects `INIT_DEFAULT`.
  - The next byte is decoded as a header.
